// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and one USER data register.
// TCK/TMS/TDI are oversampled in the system clock domain; all TAP actions run on TCK edge strobes.
module jtag_tap_responder #(
    parameter int unsigned           IR_WIDTH     = 4,
    parameter int unsigned           DR_WIDTH     = 16,
    parameter logic [IR_WIDTH-1:0]   IDCODE_INSTR = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0]   USER_INSTR   = IR_WIDTH'(4'b0010),
    parameter logic [31:0]           IDCODE_VALUE = 32'h1234_5679
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                TCK,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic                dr_update_valid
);

    typedef enum logic [3:0] {
        TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
        SHDR  = 4'd4,  EX1DR = 4'd5,  PAUDR = 4'd6,  EX2DR = 4'd7,
        UPDDR = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
        EX1IR = 4'd12, PAUIR = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15
    } tap_state_t;

    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;

    tap_state_t state, state_next;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         idcode_sr;
    logic [DR_WIDTH-1:0] user_sr;
    logic [DR_WIDTH-1:0] user_shifted;
    logic                bypass_sr;
    logic                sel_idcode, sel_user;
    logic                tdo_bit;

    // Pin synchronisers; the third TCK flop gives single-clock edge strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tck_s1 <= 1'b0;
            tck_s2 <= 1'b0;
            tck_s3 <= 1'b0;
            tms_s1 <= 1'b0;
            tms_s2 <= 1'b0;
            tdi_s1 <= 1'b0;
            tdi_s2 <= 1'b0;
        end else begin
            tck_s1 <= TCK;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tms_s1 <= TMS;
            tms_s2 <= tms_s1;
            tdi_s1 <= TDI;
            tdi_s2 <= tdi_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= TLR;
        else        state <= state_next;
    end

    // Standard TAP transition table, advanced only on a TCK rise.
    always_comb begin
        state_next = state;
        if (tck_rise) begin
            case (state)
                TLR:     state_next = tms_s2 ? TLR   : RTI;
                RTI:     state_next = tms_s2 ? SELDR : RTI;
                SELDR:   state_next = tms_s2 ? SELIR : CAPDR;
                CAPDR:   state_next = tms_s2 ? EX1DR : SHDR;
                SHDR:    state_next = tms_s2 ? EX1DR : SHDR;
                EX1DR:   state_next = tms_s2 ? UPDDR : PAUDR;
                PAUDR:   state_next = tms_s2 ? EX2DR : PAUDR;
                EX2DR:   state_next = tms_s2 ? UPDDR : SHDR;
                UPDDR:   state_next = tms_s2 ? SELDR : RTI;
                SELIR:   state_next = tms_s2 ? TLR   : CAPIR;
                CAPIR:   state_next = tms_s2 ? EX1IR : SHIR;
                SHIR:    state_next = tms_s2 ? EX1IR : SHIR;
                EX1IR:   state_next = tms_s2 ? UPDIR : PAUIR;
                PAUIR:   state_next = tms_s2 ? EX2IR : PAUIR;
                EX2IR:   state_next = tms_s2 ? UPDIR : SHIR;
                UPDIR:   state_next = tms_s2 ? SELDR : RTI;
                default: state_next = TLR;
            endcase
        end
    end

    assign tap_state  = state;
    assign sel_idcode = (ir_value == IDCODE_INSTR);
    assign sel_user   = (ir_value == USER_INSTR);

    generate
        if (DR_WIDTH > 1) begin : g_user_wide
            assign user_shifted = {tdi_s2, user_sr[DR_WIDTH-1:1]};
        end else begin : g_user_narrow
            assign user_shifted = tdi_s2;
        end
    endgenerate

    always_comb begin
        tdo_bit = bypass_sr;
        if (state == SHIR)   tdo_bit = ir_shift[0];
        else if (sel_idcode) tdo_bit = idcode_sr[0];
        else if (sel_user)   tdo_bit = user_sr[0];
    end

    // Capture/shift on TCK rise; TDO drive and updates on TCK fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_shift        <= '0;
            ir_value        <= IDCODE_INSTR;
            idcode_sr       <= '0;
            user_sr         <= '0;
            bypass_sr       <= 1'b0;
            TDO             <= 1'b0;
            tdo_oe          <= 1'b0;
            dr_update_data  <= '0;
            dr_update_valid <= 1'b0;
        end else begin
            dr_update_valid <= 1'b0;
            if (state == TLR) ir_value <= IDCODE_INSTR;

            if (tck_rise) begin
                case (state)
                    CAPIR: ir_shift <= IR_WIDTH'(2'b01);
                    SHIR:  ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
                    CAPDR: begin
                        if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
                        else if (sel_user) user_sr   <= dr_capture_data;
                        else               bypass_sr <= 1'b0;
                    end
                    SHDR: begin
                        if (sel_idcode)    idcode_sr <= {tdi_s2, idcode_sr[31:1]};
                        else if (sel_user) user_sr   <= user_shifted;
                        else               bypass_sr <= tdi_s2;
                    end
                    default: ;
                endcase
            end

            if (tck_fall) begin
                if (state == SHIR || state == SHDR) begin
                    TDO    <= tdo_bit;
                    tdo_oe <= 1'b1;
                end else begin
                    tdo_oe <= 1'b0;
                end
                if (state == UPDIR) ir_value <= ir_shift;
                if (state == UPDDR && sel_user) begin
                    dr_update_data  <= user_sr;
                    dr_update_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: expected TDO bits are queued as TDI is driven
// and popped when TDO is sampled just before each TCK rise.
module tb_jtag_tap_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        TCK, TMS, TDI;
    logic        TDO, tdo_oe;
    logic [3:0]  tap_state;
    logic [3:0]  ir_value;
    logic [15:0] dr_capture_data;
    logic [15:0] dr_update_data;
    logic        dr_update_valid;

    int total = 0;
    int bad = 0;
    int oe_seen = 0;
    int valid_cnt = 0;
    int cnt0;
    logic exp_q[$];

    jtag_tap_responder dut (
        .clock           (clock),
        .reset           (reset),
        .TCK             (TCK),
        .TMS             (TMS),
        .TDI             (TDI),
        .TDO             (TDO),
        .tdo_oe          (tdo_oe),
        .tap_state       (tap_state),
        .ir_value        (ir_value),
        .dr_capture_data (dr_capture_data),
        .dr_update_data  (dr_update_data),
        .dr_update_valid (dr_update_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dr_update_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK period; TDO is sampled late in the low phase, where a host would sample it.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v);
        logic e;
        TMS = tms_v;
        TDI = tdi_v;
        #70;
        if (tdo_oe) oe_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tdo", 32'(TDO), 32'(e));
            check("tdo_oe", 32'(tdo_oe), 32'd1);
        end
        TCK = 1'b1;
        #80;
        TCK = 1'b0;
        #10;
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, input logic [31:0] dout);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(dout[i]);
            tck_cycle(i == n - 1, din[i]);
        end
    endtask

    task automatic to_tlr();
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    endtask

    task automatic go_shift_dr();
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic go_shift_ir();
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic ir_scan(input logic [3:0] op);
        go_shift_ir();
        shift_bits(4, 32'(op), 32'h1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        TCK = 1'b0;
        TMS = 1'b1;
        TDI = 1'b0;
        dr_capture_data = 16'hA5C3;
        #38;
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_ir", 32'(ir_value), 32'h1);
        check("rst_oe", 32'(tdo_oe), 32'd0);
        check("rst_tdo", 32'(TDO), 32'd0);
        check("rst_valid", 32'(dr_update_valid), 32'd0);
        check("rst_upd", 32'(dr_update_data), 32'd0);
        reset = 1'b1;
        #20;

        // IDCODE read straight out of reset
        tck_cycle(1'b0, 1'b0);
        go_shift_dr();
        oe_seen = 0;
        shift_bits(32, 32'h0, 32'h1234_5679);
        check("idc_exit1", 32'(tap_state), 32'd5);
        tck_cycle(1'b0, 1'b0);
        check("idc_pause", 32'(tap_state), 32'd6);
        check("idc_pause_oe", 32'(tdo_oe), 32'd0);
        check("idc_oe_count", 32'(oe_seen), 32'd32);
        to_tlr();
        check("tlr_state", 32'(tap_state), 32'd0);

        // IR scan selecting USER; ir_value must not move before Update-IR
        tck_cycle(1'b0, 1'b0);
        go_shift_ir();
        shift_bits(4, 32'h2, 32'h1);
        check("ir_exit1", 32'(tap_state), 32'd12);
        check("ir_pre_upd", 32'(ir_value), 32'h1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("ir_user", 32'(ir_value), 32'h2);
        check("ir_rti", 32'(tap_state), 32'd1);

        // USER scan split by a pause
        cnt0 = valid_cnt;
        go_shift_dr();
        shift_bits(8, 32'h34, 32'hC3);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("usr_pause", 32'(tap_state), 32'd6);
        check("usr_pause_oe", 32'(tdo_oe), 32'd0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(8, 32'h12, 32'hA5);
        check("usr_pre_valid", 32'(valid_cnt - cnt0), 32'd0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("usr_upd_data", 32'(dr_update_data), 32'h1234);
        check("usr_valid_clocks", 32'(valid_cnt - cnt0), 32'd1);
        check("usr_valid_low", 32'(dr_update_valid), 32'd0);

        // TMS=1 x5 from the middle of Shift-DR
        go_shift_dr();
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
        to_tlr();
        check("abort_state", 32'(tap_state), 32'd0);
        check("abort_ir", 32'(ir_value), 32'h1);

        // BYPASS through the all-ones opcode: 0 then TDI delayed by one TCK
        tck_cycle(1'b0, 1'b0);
        ir_scan(4'hF);
        check("byp_ir", 32'(ir_value), 32'hF);
        cnt0 = valid_cnt;
        go_shift_dr();
        shift_bits(8, 32'hB4, {24'h0, 8'hB4 << 1});
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("byp_no_valid", 32'(valid_cnt - cnt0), 32'd0);

        // Sub-clock TCK glitch with TMS=1 must not move the FSM out of RTI
        TMS = 1'b1;
        #70;
        TCK = 1'b1;
        #1;
        TCK = 1'b0;
        #49;
        check("glitch_state", 32'(tap_state), 32'd1);

        // Async reset in the middle of a USER shift
        ir_scan(4'h2);
        check("rst2_ir_user", 32'(ir_value), 32'h2);
        go_shift_dr();
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
        cnt0 = valid_cnt;
        reset = 1'b0;
        #20;
        check("rst2_state", 32'(tap_state), 32'd0);
        check("rst2_ir", 32'(ir_value), 32'h1);
        check("rst2_oe", 32'(tdo_oe), 32'd0);
        check("rst2_upd", 32'(dr_update_data), 32'd0);
        check("rst2_no_valid", 32'(valid_cnt - cnt0), 32'd0);
        reset = 1'b1;
        #20;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
